// File: rtl/vga_pixel_timing.sv
// vga_pixel_timing: 640x480@60 VGA timing from CLOCK_50_I, advanced by a 25 MHz enable.
// Exports the current pixel coordinate to the colour logic and registers the returned
// RGB together with sync and blank so every DAC pin changes on the same edge.
// Optional build macro VGA_TIMING_BORDER_EN forces white on the outermost visible ring.
module vga_pixel_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output logic [9:0] oCoord_X,
    output logic [9:0] oCoord_Y,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_H_SYNC,
    output logic       oVGA_V_SYNC,
    output logic       oVGA_SYNC,
    output logic       oVGA_BLANK,
    output logic       oFrame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
`ifdef VGA_TIMING_BORDER_EN
    localparam logic [9:0] H_VIS_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST  = 10'(V_VISIBLE - 1);
`endif

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       blank_n_q, blank_n_d;
    logic       frame_start_q, frame_start_d;
    logic       visible;
    logic       border;

    // Next raster position: advance one pixel per enable, wrapping line then frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (enable) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Output stage inputs, all derived from the pre-increment position so pins stay aligned.
    always_comb begin
        visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
`ifdef VGA_TIMING_BORDER_EN
        border  = visible && ((h_cnt_q == 10'd0) || (h_cnt_q == H_VIS_LAST) ||
                              (v_cnt_q == 10'd0) || (v_cnt_q == V_VIS_LAST));
`else
        border  = 1'b0;
`endif
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        hsync_n_d     = hsync_n_q;
        vsync_n_d     = vsync_n_q;
        blank_n_d     = blank_n_q;
        // The frame marker is a single CLOCK_50_I pulse, so it clears even without enable.
        frame_start_d = enable && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        if (enable) begin
            if (border) begin
                red_d   = 8'hFF;
                green_d = 8'hFF;
                blue_d  = 8'hFF;
            end else if (visible) begin
                red_d   = iRed;
                green_d = iGreen;
                blue_d  = iBlue;
            end else begin
                red_d   = 8'h00;
                green_d = 8'h00;
                blue_d  = 8'h00;
            end
            blank_n_d = visible;
            hsync_n_d = ~((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
            vsync_n_d = ~((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
        end
    end

    // Raster counters.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // DAC output register: colour, syncs, blank and frame marker from one stage.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oCoord_X     = h_cnt_q;
    assign oCoord_Y     = v_cnt_q;
    assign oVGA_R       = red_q;
    assign oVGA_G       = green_q;
    assign oVGA_B       = blue_q;
    assign oVGA_H_SYNC  = hsync_n_q;
    assign oVGA_V_SYNC  = vsync_n_q;
    assign oVGA_SYNC    = 1'b0;
    assign oVGA_BLANK   = blank_n_q;
    assign oFrame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Directed bench for vga_pixel_timing. Instance u_a uses the standard 640x480 timing;
// instance u_b keeps the standard line but has a 12-line frame (6 visible, sync on
// lines 8..9) so whole frames, vsync and the border rows fit in a short run.
module tb_vga_pixel_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       enable;
    logic [7:0] r_drv;
    logic [7:0] b_drv;
    logic       g_use_x;

    logic [9:0] ax, ay, bx, by;
    logic [7:0] ar, ag, ab, br, bg, bb;
    logic       ahs, avs, asy, ablank, afs;
    logic       bhs, bvs, bsy, bblank, bfs;
    logic [7:0] a_gin, b_gin;

    // Green follows the exported X coordinate so colour/position alignment is visible.
    assign a_gin = g_use_x ? ax[7:0] : 8'h00;
    assign b_gin = g_use_x ? bx[7:0] : 8'h00;

    vga_pixel_timing u_a (
        .CLOCK_50_I(clk), .resetn(resetn), .enable(enable),
        .iRed(r_drv), .iGreen(a_gin), .iBlue(b_drv),
        .oCoord_X(ax), .oCoord_Y(ay),
        .oVGA_R(ar), .oVGA_G(ag), .oVGA_B(ab),
        .oVGA_H_SYNC(ahs), .oVGA_V_SYNC(avs), .oVGA_SYNC(asy),
        .oVGA_BLANK(ablank), .oFrame_start(afs)
    );

    vga_pixel_timing #(
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_b (
        .CLOCK_50_I(clk), .resetn(resetn), .enable(enable),
        .iRed(r_drv), .iGreen(b_gin), .iBlue(b_drv),
        .oCoord_X(bx), .oCoord_Y(by),
        .oVGA_R(br), .oVGA_G(bg), .oVGA_B(bb),
        .oVGA_H_SYNC(bhs), .oVGA_V_SYNC(bvs), .oVGA_SYNC(bsy),
        .oVGA_BLANK(bblank), .oFrame_start(bfs)
    );

`ifdef VGA_TIMING_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic afs1, bfs1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel period: an enable cycle followed by a hold cycle; samples #1 after each edge.
    task automatic pix();
        enable = 1'b1;
        @(posedge clk); #1;
        afs1 = afs;
        bfs1 = bfs;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    int hs_low, hs_first, a_fs_cnt, vs_low, b_fs_n, a_fs_extra;
    int b_fs_cyc[4];
    int th[6] = '{5, 0, 639, 5, 5, 640};
    int tv[6] = '{0, 1, 1, 1, 5, 1};
    int tb[6] = '{1, 1, 1, 0, 1, 0};

    initial begin
        resetn  = 1'b1;
        enable  = 1'b0;
        r_drv   = 8'hFF;
        b_drv   = 8'h00;
        g_use_x = 1'b1;

        // Asynchronous reset, before any clock edge.
        #2 resetn = 1'b0;
        #1;
        chk("rst_x", 32'(ax), 0);
        chk("rst_y", 32'(ay), 0);
        chk("rst_r", 32'(ar), 0);
        chk("rst_g", 32'(ag), 0);
        chk("rst_b", 32'(ab), 0);
        chk("rst_hs", 32'(ahs), 1);
        chk("rst_vs", 32'(avs), 1);
        chk("rst_sync", 32'(asy), 0);
        chk("rst_blank", 32'(ablank), 0);
        chk("rst_fs", 32'(afs), 0);
        chk("rst_b_sync", 32'(bsy), 0);
        chk("rst_b_hs", 32'(bhs), 1);

        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        // Released but no enable: everything holds.
        repeat (3) @(posedge clk); #1;
        chk("idle_x", 32'(ax), 0);
        chk("idle_y", 32'(ay), 0);
        chk("idle_r", 32'(ar), 0);
        chk("idle_blank", 32'(ablank), 0);
        chk("idle_hs", 32'(ahs), 1);
        chk("idle_fs", 32'(afs), 0);
        chk("idle_bx", 32'(bx), 0);

        // First full line on the standard-timing instance.
        hs_low = 0; hs_first = -1; a_fs_cnt = 0; b_fs_n = 0;
        for (int k = 0; k < 800; k++) begin
            pix();
            if (afs1) a_fs_cnt++;
            if (bfs1 && b_fs_n < 4) begin b_fs_cyc[b_fs_n] = cyc; b_fs_n++; end
            chk("fs_width", 32'(afs), 0);
            chk("line_r", 32'(ar), (k < 640) ? 255 : 0);
            chk("line_g", 32'(ag), (k < 640) ? (k % 256) : 0);
            chk("line_blank", 32'(ablank), (k < 640) ? 1 : 0);
            chk("line_hs", 32'(ahs), (k >= 656 && k < 752) ? 0 : 1);
            chk("line_vs", 32'(avs), 1);
            if (!ahs) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
        end
        chk("line_end_x", 32'(ax), 0);
        chk("line_end_y", 32'(ay), 1);
        chk("hs_low_ticks", 32'(hs_low), 96);
        chk("hs_first_tick", 32'(hs_first), 656);
        chk("fs_first_line", 32'(a_fs_cnt), 1);

        // Complete a frame on the short-frame instance and start the next one.
        vs_low = 0; a_fs_extra = 0;
        for (int t = 800; t <= 9600; t++) begin
            pix();
            if (afs1) a_fs_extra++;
            if (bfs1 && b_fs_n < 4) begin b_fs_cyc[b_fs_n] = cyc; b_fs_n++; end
            if (t < 9600 && !bvs) vs_low++;
            chk("frame_vs", 32'(bvs), (((t / 800) % 12) == 8 || ((t / 800) % 12) == 9) ? 0 : 1);
            chk("frame_blank", 32'(bblank), ((t % 800) < 640 && ((t / 800) % 12) < 6) ? 1 : 0);
        end
        chk("vs_low_ticks", 32'(vs_low), 1600);
        chk("fs_per_frame", 32'(b_fs_n), 2);
        chk("fs_period", 32'(b_fs_cyc[1] - b_fs_cyc[0]), 19200);
        chk("fs_a_none", 32'(a_fs_extra), 0);
        chk("frame_ax", 32'(ax), 1);
        chk("frame_ay", 32'(ay), 12);
        chk("frame_bx", 32'(bx), 1);
        chk("frame_by", 32'(by), 0);
        chk("frame_avs", 32'(avs), 1);

        // Move to (300,12) on u_a, then reset between clock edges.
        for (int t = 0; t < 299; t++) pix();
        chk("pre_rst_x", 32'(ax), 300);
        chk("pre_rst_r", 32'(ar), 255);
        chk("pre_rst_g", 32'(ag), 299 % 256);
        @(negedge clk) resetn = 1'b0;
        #1;
        chk("mid_rst_x", 32'(ax), 0);
        chk("mid_rst_y", 32'(ay), 0);
        chk("mid_rst_r", 32'(ar), 0);
        chk("mid_rst_g", 32'(ag), 0);
        chk("mid_rst_blank", 32'(ablank), 0);
        chk("mid_rst_hs", 32'(ahs), 1);
        chk("mid_rst_bx", 32'(bx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        pix();
        chk("restart_fs", 32'(afs1), 1);
        chk("restart_x", 32'(ax), 1);
        chk("restart_y", 32'(ay), 0);
        chk("restart_r", 32'(ar), 255);
        chk("restart_blank", 32'(ablank), 1);

        // Screen-edge pixels with black input on the short-frame instance.
        r_drv = 8'h00; b_drv = 8'h00; g_use_x = 1'b0;
        for (int n = 1; n <= 4005; n++) begin
            pix();
            for (int j = 0; j < 6; j++) begin
                if ((n % 800) == th[j] && (n / 800) == tv[j]) begin
                    chk("edge_r", 32'(br), (tb[j] == 1 && BORDER_ON) ? 255 : 0);
                    chk("edge_g", 32'(bg), (tb[j] == 1 && BORDER_ON) ? 255 : 0);
                    chk("edge_b", 32'(bb), (tb[j] == 1 && BORDER_ON) ? 255 : 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pixel_timing.md
Name: vga_pixel_timing

Overview:
Downstream stage of the object/colour generator. Produces 640x480@60 Hz VGA timing from CLOCK_50_I, gated by a 25 MHz enable. Exports the current pixel coordinates to the upstream colour logic, then registers the returned RGB aligned with the sync and blank outputs to drive the DAC pins.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
CLOCK_50_I  in  1  50 MHz clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  pixel tick; 1 on alternate CLOCK_50_I cycles
iRed  in  8  red for current coordinate, combinational from oCoord_X/oCoord_Y
iGreen  in  8  green, same rule
iBlue  in  8  blue, same rule
oCoord_X  out  10  current horizontal count h_cnt
oCoord_Y  out  10  current vertical count v_cnt
oVGA_R  out  8  registered red to DAC
oVGA_G  out  8  registered green to DAC
oVGA_B  out  8  registered blue to DAC
oVGA_H_SYNC  out  1  hsync, active-low
oVGA_V_SYNC  out  1  vsync, active-low
oVGA_SYNC  out  1  composite sync, constant 0
oVGA_BLANK  out  1  active-low blank (1 = visible pixel)
oFrame_start  out  1  one-CLOCK_50_I-cycle pulse at pixel (0,0)

Behaviour:
- Reset is asynchronous on resetn low. Applies at any time, including mid-frame.
- Reset values: h_cnt=0, v_cnt=0, RGB=0, H_SYNC=1, V_SYNC=1, BLANK=0, SYNC=0, oFrame_start=0.
- Derived totals: H_TOTAL = sum of the four H parameters = 800. V_TOTAL = sum of the four V parameters = 525.
- All state updates only on a CLOCK_50_I edge with enable=1. When enable=0, every register holds.
- Counters, on each enable cycle:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1: h_cnt <= 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with h_cnt wrap: v_cnt <= 0.
- oCoord_X = h_cnt and oCoord_Y = v_cnt, unregistered from the counters. Values outside the visible area are passed through; upstream masks them.
- visible = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE).
- Output register, on each enable cycle, computed from the pre-increment counts:
  - RGB <= visible ? iRed/iGreen/iBlue : 0.
  - BLANK <= visible.
  - H_SYNC <= ~(H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for h_cnt 656..751.
  - V_SYNC <= ~(V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for v_cnt 490..491.
- Latency: pixel (h,v) appears on the pins one CLOCK_50_I cycle after its enable cycle. It holds for 2 cycles, i.e. one pixel period.
- Sync, blank and colour come from the same register stage, so they are always mutually aligned.
- oFrame_start: set to 1 on the enable cycle where h_cnt=0 and v_cnt=0. Cleared on the next CLOCK_50_I edge regardless of enable.
- Upstream colour logic must settle within one 20 ns CLOCK_50_I period. Longer paths fail timing; this block adds no extra slack.

Optional Feature:
VGA_TIMING_BORDER_EN
- Defined: any visible pixel with h_cnt in {0, H_VISIBLE-1} or v_cnt in {0, V_VISIBLE-1} registers RGB = FF/FF/FF, overriding iRed/iGreen/iBlue. This is a screen-edge alignment aid.
- Not defined: the border pixels carry the input colour like every other visible pixel. No border logic is synthesised.

Test Plan:
- Reset then release, no enable -> all outputs hold reset values; oCoord = (0,0).
- enable toggling; iRed=FF, iGreen=00, iBlue=00 -> after 800 enable ticks oCoord_X returns to 0 and oCoord_Y=1. oVGA_R=FF exactly for h 0..639; BLANK low for h 640..799.
- Count hsync over one line -> H_SYNC low for exactly 96 ticks, starting the cycle after the enable tick at h_cnt=656.
- Full frame (420000 enable ticks) -> V_SYNC low for 1600 ticks (lines 490..491). oFrame_start pulses once per frame, width 1 CLOCK_50_I cycle. Period = 840000 CLOCK_50_I cycles.
- resetn low mid-frame at (h=300, v=200) -> outputs return to reset values immediately (asynchronously); after release, counting restarts at (0,0).
- With VGA_TIMING_BORDER_EN and inputs all 00 -> RGB = FF/FF/FF at (0,5), (639,5), (5,0), (5,479); 00 at (5,5).
